msrv32_dmem_ahb_slave: RTL and testbench

// - Data-memory slave directly downstream of the core's data port. Consumes dmaddr/dmdata/dmwr_req/dmwr_mask/data_htrans.
// - Returns dmdata_in, data_hready and hresp to the core: on-chip SRAM, configurable wait states, two-cycle AHB-Lite ERROR response.
// - Write data is presented by the core in the same cycle as the address; read data is consumed one stage later by the load unit.

---
 rtl/msrv32_bus_pkg.sv | 11 +
 rtl/msrv32_dmem_sram.sv | 21 ++
 rtl/msrv32_dmem_ahb_slave.sv | 96 +++++++++
 tb/tb_msrv32_dmem_ahb_slave.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/msrv32_bus_pkg.sv
// msrv32_bus_pkg: shared AHB-Lite encodings, slave FSM states and byte-lane mask type
package msrv32_bus_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} dmem_state_e;
    typedef logic [3:0] byte_mask_t;
endpackage

// File: rtl/msrv32_dmem_sram.sv
// msrv32_dmem_sram: synchronous-read word SRAM with per-byte write enables, read returns pre-write contents
module msrv32_dmem_sram
    import msrv32_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  byte_mask_t                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
endmodule

// File: rtl/msrv32_dmem_ahb_slave.sv
// msrv32_dmem_ahb_slave: AHB-Lite data-memory slave with wait states, ERROR response and write-to-read forwarding
module msrv32_dmem_ahb_slave
    import msrv32_bus_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] haddr_in,
    input  logic [1:0]  htrans_in,
    input  logic        hwrite_in,
    input  logic [3:0]  hwmask_in,
    input  logic [31:0] hwdata_in,
    output logic        hready_out,
    output logic        hresp_out,
    output logic [31:0] hrdata_out
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    dmem_state_e state;
    logic [3:0] cnt;
    logic [AW-1:0] idx_q, idx_in, raddr;
    logic wr_q, fwd_q, in_range, accept, commit, rd_phase, fwd_hit, unused_ok;
    byte_mask_t mask_q, fwd_mask_q;
    logic [31:0] wdata_q, fwd_data_q, hold_q, sram_rdata, rdata, off;
    assign off       = haddr_in - MEM_BASE;
    assign in_range  = haddr_in >= MEM_BASE && off < 32'(4 * DEPTH_WORDS);
    assign idx_in    = off[AW+1:2];
    assign unused_ok = ^{htrans_in[0], off[1:0], off[31:AW+2]};
    assign accept    = hready_out && htrans_in[1];
    assign commit    = state == ST_DATA && hready_out && wr_q;
    assign rd_phase  = state == ST_DATA && hready_out && !wr_q;
    // a new address is read on its accept edge so zero-wait reads have data in the next cycle
    assign raddr     = accept ? idx_in : idx_q;
    assign fwd_hit   = commit && accept && in_range && !hwrite_in && idx_in == idx_q;
    msrv32_dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk  (ms_riscv32_mp_clk_in),
        .we   (commit && ms_riscv32_mp_rst_in),
        .be   (mask_q),
        .waddr(idx_q),
        .wdata(wdata_q),
        .raddr(raddr),
        .rdata(sram_rdata)
    );
    always_comb begin
        rdata = sram_rdata;
        for (int i = 0; i < 4; i++)
            rdata[i*8 +: 8] = fwd_q && fwd_mask_q[i] ? fwd_data_q[i*8 +: 8] : sram_rdata[i*8 +: 8];
    end
    assign hrdata_out = rd_phase ? rdata : state == ST_ERR1 ? '0 : hold_q;
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hready_out <= 1'b1;
            hresp_out  <= HRESP_OKAY;
            wr_q       <= 1'b0;
            fwd_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            fwd_q      <= fwd_hit;
            fwd_mask_q <= mask_q;
            fwd_data_q <= wdata_q;
            if (rd_phase) hold_q <= rdata;
            if (accept) begin
                idx_q   <= idx_in;
                wr_q    <= hwrite_in;
                mask_q  <= hwmask_in;
                wdata_q <= hwdata_in;
            end
            if (state == ST_DATA && !hready_out) begin
                cnt        <= cnt - 4'd1;
                hready_out <= cnt == 4'd1;
            end else if (state == ST_ERR1) begin
                state      <= ST_ERR2;
                hready_out <= 1'b1;
                hresp_out  <= HRESP_ERROR;
            end else if (accept && in_range) begin
                state      <= ST_DATA;
                cnt        <= WS;
                hready_out <= WS == 4'd0;
                hresp_out  <= HRESP_OKAY;
            end else if (accept) begin
                state      <= ST_ERR1;
                hready_out <= 1'b0;
                hresp_out  <= HRESP_ERROR;
            end else begin
                state      <= ST_IDLE;
                hready_out <= 1'b1;
                hresp_out  <= HRESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_msrv32_dmem_ahb_slave.sv
// tb_msrv32_dmem_ahb_slave: directed and random checks of three slaves with 0, 2 and 3 wait states
module tb_msrv32_dmem_ahb_slave;
    import msrv32_bus_pkg::*;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] TOP  = BASE + 32'd4096;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] haddr[3], hwdata[3], hrdata[3];
    logic [1:0]  htrans[3];
    logic [3:0]  hwmask[3];
    logic        hwrite[3], hready[3], hresp[3];
    int n_checks = 0, n_errors = 0;
    logic [31:0] mdl[2][16];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        msrv32_dmem_ahb_slave #(.MEM_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
            .ms_riscv32_mp_clk_in(clk),
            .ms_riscv32_mp_rst_in(rst_n),
            .haddr_in(haddr[g]),
            .htrans_in(htrans[g]),
            .hwrite_in(hwrite[g]),
            .hwmask_in(hwmask[g]),
            .hwdata_in(hwdata[g]),
            .hready_out(hready[g]),
            .hresp_out(hresp[g]),
            .hrdata_out(hrdata[g])
        );
    end
    function automatic int ws(input int d);
        return d == 0 ? 0 : d + 1;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // called at a negedge while the slave is ready; returns at the negedge of the data-phase ready cycle
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rs, output int waits);
        haddr[d] = a; htrans[d] = HTRANS_NONSEQ; hwrite[d] = w; hwmask[d] = m; hwdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
        waits = 0;
        while (!hready[d] && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        rd = hrdata[d];
        rs = hresp[d];
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] rd, a, wd;
        logic rs, w;
        logic [3:0] m;
        int waits, k, kind;
        for (int d = 0; d < 3; d++) begin
            haddr[d] = '0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0; hwmask[d] = '0; hwdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset hready", 32'(hready[d]), 32'd1);
            check("reset hresp", 32'(hresp[d]), 32'd0);
            check("reset hrdata", hrdata[d], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, 1'b1, BASE, 4'hF, 32'hDEAD_BEEF, rd, rs, waits);
        check("ws0 write resp", 32'(rs), 32'd0);
        xfer(0, 1'b0, BASE, 4'h0, 32'h0, rd, rs, waits);
        check("ws0 read waits", 32'(waits), 32'd0);
        check("ws0 read resp", 32'(rs), 32'd0);
        check("ws0 read data", rd, 32'hDEAD_BEEF);
        xfer(0, 1'b1, BASE + 8, 4'hF, 32'hAAAA_AAAA, rd, rs, waits);
        xfer(0, 1'b1, BASE + 8, 4'b0011, 32'h1122_3344, rd, rs, waits);
        xfer(0, 1'b0, BASE + 8, 4'h0, 32'h0, rd, rs, waits);
        check("b2b fwd waits", 32'(waits), 32'd0);
        check("b2b fwd data", rd, 32'hAAAA_3344);
        xfer(0, 1'b1, BASE + 12, 4'h0, 32'hFFFF_FFFF, rd, rs, waits);
        check("mask0 resp", 32'(rs), 32'd0);
        xfer(0, 1'b0, BASE + 12, 4'h0, 32'h0, rd, rs, waits);
        xfer(0, 1'b0, BASE + 8, 4'h0, 32'h0, rd, rs, waits);
        check("b2b stored data", rd, 32'hAAAA_3344);
        haddr[0] = TOP; htrans[0] = HTRANS_NONSEQ; hwrite[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        htrans[0] = HTRANS_IDLE;
        check("err1 hready", 32'(hready[0]), 32'd0);
        check("err1 hresp", 32'(hresp[0]), 32'd1);
        check("err1 hrdata", hrdata[0], 32'd0);
        @(negedge clk);
        check("err2 hready", 32'(hready[0]), 32'd1);
        check("err2 hresp", 32'(hresp[0]), 32'd1);
        @(negedge clk);
        check("err idle hready", 32'(hready[0]), 32'd1);
        check("err idle hresp", 32'(hresp[0]), 32'd0);
        xfer(0, 1'b1, TOP, 4'hF, 32'h1234_5678, rd, rs, waits);
        check("oor write resp", 32'(rs), 32'd1);
        check("oor write waits", 32'(waits), 32'd1);
        xfer(0, 1'b0, BASE - 4, 4'h0, 32'h0, rd, rs, waits);
        check("below base resp", 32'(rs), 32'd1);
        xfer(0, 1'b0, BASE, 4'h0, 32'h0, rd, rs, waits);
        check("oor no alias", rd, 32'hDEAD_BEEF);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            htrans[0] = t == 0 ? HTRANS_BUSY : HTRANS_IDLE;
            hwrite[0] = 1'b1; haddr[0] = BASE; hwmask[0] = 4'hF; hwdata[0] = 32'h0;
            @(negedge clk);
            check("busy/idle hready", 32'(hready[0]), 32'd1);
            check("busy/idle hresp", 32'(hresp[0]), 32'd0);
        end
        htrans[0] = HTRANS_IDLE; hwrite[0] = 1'b0;
        xfer(0, 1'b0, BASE, 4'h0, 32'h0, rd, rs, waits);
        check("busy/idle no write", rd, 32'hDEAD_BEEF);
        xfer(1, 1'b1, BASE + 4, 4'hF, 32'hCAFE_F00D, rd, rs, waits);
        check("ws2 write waits", 32'(waits), 32'd2);
        xfer(1, 1'b0, BASE + 4, 4'h0, 32'h0, rd, rs, waits);
        check("ws2 read waits", 32'(waits), 32'd2);
        check("ws2 read data", rd, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        check("ws2 hrdata hold", hrdata[1], 32'hCAFE_F00D);
        xfer(2, 1'b1, BASE + 12, 4'hF, 32'h5555_AAAA, rd, rs, waits);
        haddr[2] = BASE + 12; htrans[2] = HTRANS_NONSEQ; hwrite[2] = 1'b1; hwmask[2] = 4'hF; hwdata[2] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        htrans[2] = HTRANS_IDLE; hwrite[2] = 1'b0;
        check("ws3 mid-wait hready", 32'(hready[2]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst mid hready", 32'(hready[2]), 32'd1);
        check("rst mid hresp", 32'(hresp[2]), 32'd0);
        check("rst mid hrdata", hrdata[2], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(2, 1'b0, BASE + 12, 4'h0, 32'h0, rd, rs, waits);
        check("rst dropped write", rd, 32'h5555_AAAA);
        check("ws3 read waits", 32'(waits), 32'd3);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                mdl[d][i] = $urandom;
                xfer(d, 1'b1, BASE + 32'(4 * (64 + i)), 4'hF, mdl[d][i], rd, rs, waits);
                check("init resp", 32'(rs), 32'd0);
            end
            for (int n = 0; n < 150; n++) begin
                kind = $urandom_range(0, 9);
                k = $urandom_range(0, 15);
                w = 1'($urandom_range(0, 1));
                m = 4'($urandom_range(0, 15));
                wd = $urandom;
                if (kind == 0)
                    a = $urandom_range(0, 1) == 1 ? TOP + 32'(4 * (64 + k)) : BASE - 32'(4 * (1 + k));
                else
                    a = BASE + 32'(4 * (64 + k)) + 32'($urandom_range(0, 3));
                xfer(d, w, a, m, wd, rd, rs, waits);
                if (kind == 0) begin
                    check("rand oor resp", 32'(rs), 32'd1);
                    check("rand oor waits", 32'(waits), 32'd1);
                end else begin
                    check("rand resp", 32'(rs), 32'd0);
                    check("rand waits", 32'(waits), 32'(ws(d)));
                    if (!w) check("rand read data", rd, mdl[d][k]);
                    else
                        for (int i = 0; i < 4; i++)
                            if (m[i]) mdl[d][k][i*8 +: 8] = wd[i*8 +: 8];
                end
            end
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
